// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Contents:
//   - field widths (opcode, ALU op)
//   - opcode constants and ALU operation codes
//   - FSM state encoding (also driven onto the debug state port)
//   - PC source select codes
//   - instruction class enum plus op_class(), which maps a raw opcode onto
//     the sequencing class the FSM cares about. Unknown opcodes map to C_NOP.
package cpu_defs_pkg;

  localparam int CPU_OP_W    = 6;
  localparam int CPU_ALUOP_W = 3;

  localparam logic [CPU_OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [CPU_OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [CPU_OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [CPU_OP_W-1:0] OP_ANDI  = 6'b010000;
  localparam logic [CPU_OP_W-1:0] OP_AND   = 6'b010001;
  localparam logic [CPU_OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [CPU_OP_W-1:0] OP_OR    = 6'b010011;
  localparam logic [CPU_OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [CPU_OP_W-1:0] OP_SLTI  = 6'b011100;
  localparam logic [CPU_OP_W-1:0] OP_SW    = 6'b100110;
  localparam logic [CPU_OP_W-1:0] OP_LW    = 6'b100111;
  localparam logic [CPU_OP_W-1:0] OP_BEQ   = 6'b110000;
  localparam logic [CPU_OP_W-1:0] OP_BNE   = 6'b110001;
  localparam logic [CPU_OP_W-1:0] OP_BLTZ  = 6'b110010;
  localparam logic [CPU_OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [CPU_OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [CPU_ALUOP_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [CPU_ALUOP_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [CPU_ALUOP_W-1:0] ALU_AND  = 3'd2;
  localparam logic [CPU_ALUOP_W-1:0] ALU_OR   = 3'd3;
  localparam logic [CPU_ALUOP_W-1:0] ALU_SLL  = 3'd4;
  localparam logic [CPU_ALUOP_W-1:0] ALU_SLTI = 3'd5;

  localparam logic [1:0] PC_SEQ = 2'd0;  // PC+4
  localparam logic [1:0] PC_BR  = 2'd1;  // branch target
  localparam logic [1:0] PC_JMP = 2'd2;  // jump target

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_BLTZ, C_J, C_HALT
  } iclass_t;

  function automatic iclass_t op_class(input logic [CPU_OP_W-1:0] op);
    iclass_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL: c = C_RTYPE;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:    c = C_IMM;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_BNE:  c = C_BNE;
      OP_BLTZ: c = C_BLTZ;
      OP_J:    c = C_J;
      OP_HALT: c = C_HALT;
      default: c = C_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode -> datapath select decode.
// Ports:
//   opcode  in  IR[31:26]
//   aluOp   out ALU operation
//   ALUSrcA out 0 rs, 1 shamt (sll only)
//   ALUSrcB out 0 rt, 1 extended immediate
//   ExtSel  out 0 zero-extend, 1 sign-extend
//   RegDst  out 1 for R-type (write rd), 0 otherwise
// Pure decode; the FSM decides in which states these values reach the pins.
module alu_op_decode
  import cpu_defs_pkg::*;
#(
  parameter int OP_W    = CPU_OP_W,
  parameter int ALUOP_W = CPU_ALUOP_W
) (
  input  logic [OP_W-1:0]    opcode,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               RegDst
);

  always_comb begin
    aluOp   = ALU_ADD;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    ExtSel  = 1'b0;
    RegDst  = 1'b0;
    case (opcode)
      OP_ADD:   RegDst = 1'b1;
      OP_SUB:   begin aluOp = ALU_SUB; RegDst = 1'b1; end
      OP_AND:   begin aluOp = ALU_AND; RegDst = 1'b1; end
      OP_OR:    begin aluOp = ALU_OR;  RegDst = 1'b1; end
      OP_SLL:   begin aluOp = ALU_SLL; ALUSrcA = 1'b1; RegDst = 1'b1; end
      OP_ADDIU: begin ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_ANDI:  begin aluOp = ALU_AND; ALUSrcB = 1'b1; end
      OP_ORI:   begin aluOp = ALU_OR;  ALUSrcB = 1'b1; end
      OP_SLTI:  begin aluOp = ALU_SLTI; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_LW, OP_SW: begin ALUSrcB = 1'b1; ExtSel = 1'b1; end
      // bltz compares rs against $0 through the rt port (rt field is 0)
      OP_BEQ, OP_BNE, OP_BLTZ: begin aluOp = ALU_SUB; ExtSel = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle control FSM: sequences each instruction through IF/ID/EXE/MEM/WB,
// drives the ALU op and datapath selects, resolves branches from Zero/Sign.
// Ports:
//   CLK, Reset          clock, async active-high reset
//   opcode              IR[31:26], stable from ID onward
//   Zero, Sign          ALU flags, only looked at in EXE
//   PCWre, IRWre        PC / IR write enables
//   PCSrc               0 PC+4, 1 branch, 2 jump
//   ALUSrcA/B, ExtSel, aluOp   datapath selects, live in EXE/MEM/WB
//   RegWre, RegDst, WrRegDSrc  register write-back control (WB only)
//   mRD, mWR            data memory strobes (MEM only)
//   state               current FSM state for debug
// Only the state register is sequential; every output is decoded from
// state + opcode (+ flags in EXE), and forced low while Reset is high so an
// aborted instruction can never leave a partial write behind.
module multicycle_ctrl_unit
  import cpu_defs_pkg::*;
#(
  parameter int OP_W    = CPU_OP_W,
  parameter int ALUOP_W = CPU_ALUOP_W
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               Zero,
  input  logic               Sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               RegWre,
  output logic               RegDst,
  output logic               WrRegDSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [2:0]         state
);

  state_t  cur, nxt;
  iclass_t cls;

  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_srca, dec_srcb, dec_ext, dec_regdst;

  alu_op_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec (
    .opcode  (opcode),
    .aluOp   (dec_aluop),
    .ALUSrcA (dec_srca),
    .ALUSrcB (dec_srcb),
    .ExtSel  (dec_ext),
    .RegDst  (dec_regdst)
  );

  assign cls   = op_class(opcode);
  assign state = cur;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF: nxt = S_ID;
      S_ID: begin
        case (cls)
          C_J, C_NOP: nxt = S_IF;
          C_HALT:     nxt = S_HALT;
          default:    nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_LW, C_SW:       nxt = S_MEM;
          C_RTYPE, C_IMM:   nxt = S_WB;
          default:          nxt = S_IF;  // branches finish here
        endcase
      end
      S_MEM:   nxt = (cls == C_LW) ? S_WB : S_IF;
      S_WB:    nxt = S_IF;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IF;  // unused encodings recover to fetch
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    PCSrc     = PC_SEQ;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    aluOp     = '0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    WrRegDSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    if (!Reset) begin
      // ALU controls are set up in EXE and held so MEM/WB see a stable result
      if (cur == S_EXE || cur == S_MEM || cur == S_WB) begin
        aluOp   = dec_aluop;
        ALUSrcA = dec_srca;
        ALUSrcB = dec_srcb;
        ExtSel  = dec_ext;
      end
      case (cur)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          case (cls)
            C_J:     begin PCWre = 1'b1; PCSrc = PC_JMP; end
            C_NOP:   PCWre = 1'b1;
            default: ;
          endcase
        end
        S_EXE: begin
          case (cls)
            C_BEQ:   begin PCWre = 1'b1; PCSrc = Zero ? PC_BR : PC_SEQ; end
            C_BNE:   begin PCWre = 1'b1; PCSrc = Zero ? PC_SEQ : PC_BR; end
            C_BLTZ:  begin PCWre = 1'b1; PCSrc = Sign ? PC_BR : PC_SEQ; end
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls == C_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end else if (cls == C_LW) begin
            mRD = 1'b1;
          end
        end
        S_WB: begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          RegDst    = dec_regdst;
          WrRegDSrc = (cls == C_LW);
        end
        default: ;  // HALT: everything stays low
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
module tb_multicycle_ctrl_unit;

  logic       CLK, Reset, Zero, Sign;
  logic [5:0] opcode;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, RegDst, WrRegDSrc, mRD, mWR;
  logic [1:0] PCSrc;
  logic [2:0] aluOp, state;

  multicycle_ctrl_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .Zero(Zero), .Sign(Sign),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .aluOp(aluOp), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010,
    ANDI = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010, OR_ = 6'b010011,
    SLL = 6'b011000, SLTI = 6'b011100, SW = 6'b100110, LW = 6'b100111,
    BEQ = 6'b110000, BNE = 6'b110001, BLTZ = 6'b110010, J = 6'b111000,
    HALT = 6'b111111, NOP = 6'b000011;

  // {state, PCWre, IRWre, PCSrc, ALUSrcA, ALUSrcB, ExtSel, aluOp, RegWre, RegDst, WrRegDSrc, mRD, mWR}
  logic [17:0] actv;
  assign actv = {state, PCWre, IRWre, PCSrc, ALUSrcA, ALUSrcB, ExtSel, aluOp,
                 RegWre, RegDst, WrRegDSrc, mRD, mWR};

  int ncmp = 0, nbad = 0;

  task automatic chk(input string nm, input logic [17:0] a, input logic [17:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    ncmp++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // ---------------- reference model: instruction-level rules ----------------
  function automatic bit is_r(input logic [5:0] op);
    return op == ADD || op == SUB || op == AND_ || op == OR_ || op == SLL;
  endfunction
  function automatic bit is_i(input logic [5:0] op);
    return op == ADDIU || op == ANDI || op == ORI || op == SLTI;
  endfunction
  function automatic bit is_br(input logic [5:0] op);
    return op == BEQ || op == BNE || op == BLTZ;
  endfunction

  // cycles from IF through the cycle that writes the PC
  function automatic int ilen(input logic [5:0] op);
    if (op == LW) return 5;
    if (op == SW || is_r(op) || is_i(op)) return 4;
    if (is_br(op)) return 3;
    return 2;  // j, nop, halt (halt then parks)
  endfunction

  function automatic logic [2:0] st_at(input logic [5:0] op, input int k);
    if (k < 2) return 3'(k);
    if (k == 2) return 3'd2;
    if (k == 3) return (op == LW || op == SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  // {aluOp, srcA, srcB, ext}
  function automatic logic [5:0] dp(input logic [5:0] op);
    case (op)
      ADD:   return {3'd0, 3'b000};
      SUB:   return {3'd1, 3'b000};
      ADDIU: return {3'd0, 3'b011};
      ANDI:  return {3'd2, 3'b010};
      AND_:  return {3'd2, 3'b000};
      ORI:   return {3'd3, 3'b010};
      OR_:   return {3'd3, 3'b000};
      SLL:   return {3'd4, 3'b100};
      SLTI:  return {3'd5, 3'b011};
      LW, SW: return {3'd0, 3'b011};
      BEQ, BNE, BLTZ: return {3'd1, 3'b001};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [17:0] exp_out(input logic [5:0] op, input int k, input logic z, input logic s);
    logic [2:0] st, alu;
    logic [1:0] pcs;
    logic       a, b, e, pcw;
    logic [5:0] d;
    st  = st_at(op, k);
    pcw = (k == ilen(op) - 1) && op != HALT;
    pcs = 2'd0;
    if (op == J && st == 3'd1) pcs = 2'd2;
    else if (st == 3'd2) begin
      if (op == BEQ)  pcs = {1'b0, z};
      if (op == BNE)  pcs = {1'b0, ~z};
      if (op == BLTZ) pcs = {1'b0, s};
    end
    d = (st >= 3'd2) ? dp(op) : 6'd0;
    {alu, a, b, e} = d;
    return {st, pcw, st == 3'd0, pcs, a, b, e, alu,
            st == 3'd4, st == 3'd4 && is_r(op), st == 3'd4 && op == LW,
            st == 3'd3 && op == LW, st == 3'd3 && op == SW};
  endfunction

  // runs one instruction from IF; flags random each cycle when rnd is set
  task automatic run_instr(input logic [5:0] op, input bit rnd, input logic z, input logic s);
    for (int k = 0; k < ilen(op); k++) begin
      @(negedge CLK);
      opcode = op;
      Zero = rnd ? 1'($urandom_range(0, 1)) : z;
      Sign = rnd ? 1'($urandom_range(0, 1)) : s;
      #1;
      chk($sformatf("op%b_c%0d", op, k), actv, exp_out(op, k, Zero, Sign));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] op;
    logic       z, s;
    int         len, pcsrc, alu, ext;
  } vec_t;

  vec_t tbl[19];
  logic [5:0] ops[16];

  initial begin
    int cyc, pc, al, ex;
    bit done;
    logic [5:0] op;

    tbl = '{
      '{ADD,   0, 0, 4, 0, 0, 0}, '{SUB,   0, 0, 4, 0, 1, 0},
      '{ADDIU, 0, 0, 4, 0, 0, 1}, '{ANDI,  0, 0, 4, 0, 2, 0},
      '{AND_,  0, 0, 4, 0, 2, 0}, '{ORI,   0, 0, 4, 0, 3, 0},
      '{OR_,   0, 0, 4, 0, 3, 0}, '{SLL,   0, 0, 4, 0, 4, 0},
      '{SLTI,  0, 0, 4, 0, 5, 1}, '{SW,    0, 0, 4, 0, 0, 1},
      '{LW,    0, 0, 5, 0, 0, 1}, '{BEQ,   1, 0, 3, 1, 1, 1},
      '{BEQ,   0, 1, 3, 0, 1, 1}, '{BNE,   1, 0, 3, 0, 1, 1},
      '{BNE,   0, 1, 3, 1, 1, 1}, '{BLTZ,  0, 1, 3, 1, 1, 1},
      '{BLTZ,  1, 0, 3, 0, 1, 1}, '{J,     1, 1, 2, 2, 0, 0},
      '{NOP,   0, 0, 2, 0, 0, 0}
    };
    ops = '{ADD, SUB, ADDIU, ANDI, AND_, ORI, OR_, SLL, SLTI, SW, LW, BEQ, BNE, BLTZ, J, NOP};

    // reset: state IF, every output low regardless of inputs
    Reset = 1'b1; opcode = J; Zero = 1'b1; Sign = 1'b1;
    #3;
    chk("reset_j", actv, 18'h0);
    opcode = SW;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_sw", actv, 18'h0);
    #1 Reset = 1'b0;

    foreach (tbl[i]) begin
      cyc = 0; pc = -1; al = 0; ex = 0; done = 0;
      while (!done && cyc < 10) begin
        @(negedge CLK);
        opcode = tbl[i].op; Zero = tbl[i].z; Sign = tbl[i].s;
        #1;
        cyc++;
        if (state == 3'd2) begin al = int'(aluOp); ex = int'(ExtSel); end
        if (PCWre) begin pc = int'(PCSrc); done = 1; end
      end
      chki($sformatf("tbl%0d_len", i), cyc, tbl[i].len);
      chki($sformatf("tbl%0d_pcsrc", i), pc, tbl[i].pcsrc);
      chki($sformatf("tbl%0d_aluop", i), al, tbl[i].alu);
      chki($sformatf("tbl%0d_extsel", i), ex, tbl[i].ext);
    end

    // randomized instruction stream, flags toggling every cycle
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 16));
      if (r == 16) begin
        op = 6'($urandom_range(0, 63));
        if (op == HALT) op = NOP;
      end else op = ops[r];
      run_instr(op, 1'b1, 1'b0, 1'b0);
    end

    // reset pulse in EXE of lw: immediate IF, no memory/regfile activity
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      opcode = LW; Zero = 1'b0; Sign = 1'b0;
      #1;
      chk($sformatf("lwabort_c%0d", k), actv, exp_out(LW, k, 1'b0, 1'b0));
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("lwabort_reset", actv, 18'h0);
    @(posedge CLK);
    #2 Reset = 1'b0;
    run_instr(LW, 1'b0, 1'b0, 1'b0);
    run_instr(ADD, 1'b1, 1'b0, 1'b0);

    // halt parks with all enables low until reset
    run_instr(HALT, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      opcode = ops[k % 16];
      Zero = 1'($urandom_range(0, 1)); Sign = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halt_c%0d", k), actv, {3'b111, 15'h0});
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("halt_reset", actv, 18'h0);
    @(posedge CLK);
    #2 Reset = 1'b0;
    run_instr(J, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
